// File: rtl/stk_adm_arb.sv
// stk_adm_arb: round-robin admission arbiter for the stack engine LK slot.
// Gates PUSH on the allocator, filters under/overflow, tracks in-flight.

package cfg_pkg;
    localparam int ENGS_N = 4;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
endpackage

module stk_adm_arb #(
    parameter int  ENGS_N  = cfg_pkg::ENGS_N,
    parameter int  CNT_W   = 8,
    localparam int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*ENGS_N-1:0]     i_cmd_opcode,
    input  logic [128*ENGS_N-1:0]   i_cmd_dat,
    output logic [ENGS_N-1:0]       o_cmd_ack,
    input  logic                    i_al_empty_r,
    input  logic                    i_al_busy_r,
    output logic                    o_al_alloc,
    output logic                    o_lk_vld,
    output logic [ENGID_W-1:0]      o_lk_engid,
    output logic [1:0]              o_lk_opcode,
    output logic                    o_lk_dat_vld,
    output logic [127:0]            o_lk_dat,
    input  logic                    i_wrbk_uc_vld_r,
    input  logic [ENGID_W-1:0]      i_wrbk_uc_engid_r,
    output logic                    o_err_vld,
    output logic [ENGID_W-1:0]      o_err_engid,
    output logic                    o_err_ovf,
    output logic                    o_busy
);

    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [ENGID_W-1:0] RR_INIT = ENGID_W'(ENGS_N - 1);

    logic [ENGS_N-1:0]  inflight;
    logic [CNT_W-1:0]   cnt [ENGS_N];
    logic [ENGID_W-1:0] rr_ptr;

    logic [ENGS_N-1:0]  is_push;
    logic [ENGS_N-1:0]  is_pop;
    logic [ENGS_N-1:0]  cnt_full;
    logic [ENGS_N-1:0]  cnt_zero;
    logic [ENGS_N-1:0]  elig;
    logic               al_ready;

    logic               grant;
    logic [ENGID_W-1:0] win;
    logic [1:0]         win_op;
    logic [127:0]       win_dat;
    logic               win_push;
    logic               win_pop;
    logic               win_err;
    logic               issue;
    logic               err;

    logic               lk_vld_q;
    logic [ENGID_W-1:0] lk_engid_q;
    logic [1:0]         lk_opcode_q;
    logic               lk_dat_vld_q;
    logic [127:0]       lk_dat_q;
    logic               err_vld_q;
    logic [ENGID_W-1:0] err_engid_q;
    logic               err_ovf_q;

    // The allocator only matters for a PUSH that will really allocate.
    assign al_ready = !i_al_empty_r && !i_al_busy_r;

    // Per-engine opcode decode, counter bounds and eligibility.
    always_comb begin
        is_push  = '0;
        is_pop   = '0;
        cnt_full = '0;
        cnt_zero = '0;
        elig     = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            is_push[e]  = (i_cmd_opcode[2*e +: 2] == cfg_pkg::OP_PUSH);
            is_pop[e]   = (i_cmd_opcode[2*e +: 2] == cfg_pkg::OP_POP);
            cnt_full[e] = (cnt[e] == CNT_MAX);
            cnt_zero[e] = (cnt[e] == '0);
            elig[e]     = !rst && !inflight[e] &&
                          (is_pop[e] ||
                           (is_push[e] && (cnt_full[e] || al_ready)));
        end
    end

    // Round-robin search starting one past the previous winner.
    always_comb begin
        logic [ENGID_W-1:0] cand;
        grant = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= ENGS_N; k++) begin
            cand = ENGID_W'((int'(rr_ptr) + k) % ENGS_N);
            if (!grant && elig[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end
    end

    // Winner attributes and split between real issue and error report.
    always_comb begin
        win_op   = i_cmd_opcode[2*int'(win) +: 2];
        win_dat  = i_cmd_dat[128*int'(win) +: 128];
        win_push = is_push[win];
        win_pop  = is_pop[win];
        win_err  = (win_pop && cnt_zero[win]) ||
                   (win_push && cnt_full[win]);
        issue    = grant && !win_err;
        err      = grant && win_err;
    end

    // One-hot acknowledge of the winner, error grants included.
    always_comb begin
        o_cmd_ack = '0;
        if (grant) begin
            o_cmd_ack[win] = 1'b1;
        end
    end

    assign o_al_alloc = issue && win_push;
    assign o_busy     = !rst && (|inflight);

    // Arbitration pointer, in-flight flags and occupancy counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            rr_ptr   <= RR_INIT;
            for (int e = 0; e < ENGS_N; e++) begin
                cnt[e] <= '0;
            end
        end else begin
            if (grant) begin
                rr_ptr <= win;
            end
            for (int e = 0; e < ENGS_N; e++) begin
                // Retire first so a later set on the same engine wins.
                if (i_wrbk_uc_vld_r &&
                    int'(i_wrbk_uc_engid_r) == e) begin
                    inflight[e] <= 1'b0;
                end
                if (issue && int'(win) == e) begin
                    inflight[e] <= 1'b1;
                    cnt[e] <= win_push ? cnt[e] + CNT_ONE
                                       : cnt[e] - CNT_ONE;
                end
            end
        end
    end

    // LK issue and error report registers, one pulse per grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_vld_q     <= 1'b0;
            lk_engid_q   <= '0;
            lk_opcode_q  <= '0;
            lk_dat_vld_q <= 1'b0;
            lk_dat_q     <= '0;
            err_vld_q    <= 1'b0;
            err_engid_q  <= '0;
            err_ovf_q    <= 1'b0;
        end else begin
            lk_vld_q  <= issue;
            err_vld_q <= err;
            if (issue) begin
                lk_engid_q   <= win;
                lk_opcode_q  <= win_op;
                lk_dat_vld_q <= win_push;
                if (win_push) begin
                    lk_dat_q <= win_dat;
                end
            end
            if (err) begin
                err_engid_q <= win;
                err_ovf_q   <= win_push;
            end
        end
    end

    // A pending pulse is squashed as soon as reset is seen.
    assign o_lk_vld     = lk_vld_q && !rst;
    assign o_err_vld    = err_vld_q && !rst;
    assign o_lk_engid   = lk_engid_q;
    assign o_lk_opcode  = lk_opcode_q;
    assign o_lk_dat_vld = lk_dat_vld_q;
    assign o_lk_dat     = lk_dat_q;
    assign o_err_engid  = err_engid_q;
    assign o_err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_stk_adm_arb.sv
// tb_stk_adm_arb: vector table plus scoreboard for stk_adm_arb.
// Four engines, 2-bit counters so overflow is reachable quickly.

module tb_stk_adm_arb;

    localparam int N  = 4;
    localparam int CW = 2;

    localparam logic [1:0] NP = 2'd0;
    localparam logic [1:0] PU = 2'd1;
    localparam logic [1:0] PO = 2'd2;
    localparam logic [1:0] RS = 2'd3;

    typedef struct {
        logic [7:0] op;
        logic       emp;
        logic       abz;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] ack;
        logic       alloc;
        logic       busy;
        int         kind;
        logic       ovf;
    } vec_t;

    typedef struct {
        int         kind;
        logic [1:0] eng;
        logic [1:0] op;
        logic       ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2*N-1:0]   opc = '0;
    logic [128*N-1:0] dat = '0;
    logic [N-1:0]     ack;
    logic             al_empty = 1'b0;
    logic             al_busy = 1'b0;
    logic             alloc;
    logic             lk_vld;
    logic [1:0]       lk_engid;
    logic [1:0]       lk_opcode;
    logic             lk_dat_vld;
    logic [127:0]     lk_dat;
    logic             rv = 1'b0;
    logic [1:0]       rid = '0;
    logic             err_vld;
    logic [1:0]       err_engid;
    logic             err_ovf;
    logic             busy;

    vec_t         vecs[$];
    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [127:0] exp_dat = '0;
    logic [3:0]   infl_m = '0;

    always #5 clk = ~clk;

    stk_adm_arb #(.ENGS_N(N), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_cmd_opcode      (opc),
        .i_cmd_dat         (dat),
        .o_cmd_ack         (ack),
        .i_al_empty_r      (al_empty),
        .i_al_busy_r       (al_busy),
        .o_al_alloc        (alloc),
        .o_lk_vld          (lk_vld),
        .o_lk_engid        (lk_engid),
        .o_lk_opcode       (lk_opcode),
        .o_lk_dat_vld      (lk_dat_vld),
        .o_lk_dat          (lk_dat),
        .i_wrbk_uc_vld_r   (rv),
        .i_wrbk_uc_engid_r (rid),
        .o_err_vld         (err_vld),
        .o_err_engid       (err_engid),
        .o_err_ovf         (err_ovf),
        .o_busy            (busy)
    );

    function automatic logic [127:0] pat(input int e);
        return {32'hDA7A_0000 + 32'(e), 32'h5EED_0010 + 32'(e),
                32'hC0DE_0200 + 32'(e), 32'hBEEF_3000 + 32'(e)};
    endfunction

    function automatic vec_t mk(
        input logic [1:0] o3, input logic [1:0] o2,
        input logic [1:0] o1, input logic [1:0] o0,
        input logic emp, input logic abz,
        input logic rvv, input logic [1:0] ridv,
        input logic [3:0] acke, input logic alle,
        input logic bsye, input int kind, input logic ovf);
        vec_t v;
        v.op = {o3, o2, o1, o0};
        v.emp = emp;
        v.abz = abz;
        v.rv = rvv;
        v.rid = ridv;
        v.ack = acke;
        v.alloc = alle;
        v.busy = bsye;
        v.kind = kind;
        v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_out(input exp_t x);
        chk("lk_vld", 128'(lk_vld), 128'(x.kind == 1));
        chk("err_vld", 128'(err_vld), 128'(x.kind == 2));
        if (x.kind == 1) begin
            chk("lk_engid", 128'(lk_engid), 128'(x.eng));
            chk("lk_opcode", 128'(lk_opcode), 128'(x.op));
            chk("lk_dat_vld", 128'(lk_dat_vld), 128'(x.op == PU));
        end
        if (x.kind == 2) begin
            chk("err_engid", 128'(err_engid), 128'(x.eng));
            chk("err_ovf", 128'(err_ovf), 128'(x.ovf));
        end
        chk("lk_dat", lk_dat, exp_dat);
    endtask

    task automatic step(input vec_t v);
        exp_t x;
        int   w;
        opc = v.op;
        al_empty = v.emp;
        al_busy = v.abz;
        rv = v.rv;
        rid = v.rid;
        #1;
        chk("ack", 128'(ack), 128'(v.ack));
        chk("alloc", 128'(alloc), 128'(v.alloc));
        chk("busy", 128'(busy), 128'(v.busy));
        w = 0;
        for (int e = 0; e < N; e++) begin
            if (v.ack[e]) w = e;
        end
        x.kind = v.kind;
        x.eng = 2'(w);
        x.op = v.op[2*w +: 2];
        x.ovf = v.ovf;
        sb.push_back(x);
        if (v.rv && !infl_m[v.rid]) begin
            n_fail++;
            $display("FAIL protocol: retire of idle engine %0d", v.rid);
        end
        @(posedge clk);
        #1;
        if (v.rv) infl_m[v.rid] = 1'b0;
        if (x.kind == 1) begin
            infl_m[w] = 1'b1;
            if (x.op == PU) exp_dat = pat(w);
        end
        check_out(sb.pop_front());
        @(negedge clk);
    endtask

    initial begin
        for (int e = 0; e < N; e++) dat[128*e +: 128] = pat(e);

        // reset with every engine requesting
        opc = {PU, PU, PU, PU};
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ack", 128'(ack), 128'(0));
        chk("rst_alloc", 128'(alloc), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_lk_vld", 128'(lk_vld), 128'(0));
        chk("rst_err_vld", 128'(err_vld), 128'(0));
        chk("rst_lk_engid", 128'(lk_engid), 128'(0));
        chk("rst_lk_opcode", 128'(lk_opcode), 128'(0));
        chk("rst_lk_dat_vld", 128'(lk_dat_vld), 128'(0));
        chk("rst_lk_dat", lk_dat, 128'(0));
        chk("rst_err_engid", 128'(err_engid), 128'(0));
        chk("rst_err_ovf", 128'(err_ovf), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // all push in order, then retire all
        vecs.push_back(mk(PU,PU,PU,PU, 0,0,0,0, 4'b0001,1,0,1,0));
        vecs.push_back(mk(PU,PU,PU,NP, 0,0,0,0, 4'b0010,1,1,1,0));
        vecs.push_back(mk(PU,PU,NP,NP, 0,0,0,0, 4'b0100,1,1,1,0));
        vecs.push_back(mk(PU,NP,NP,NP, 0,0,0,0, 4'b1000,1,1,1,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,1,0, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,1,1, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,1,2, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,1,3, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,0,0, 4'b0000,0,0,0,0));
        // engine 2 pop issue, retire, then underflow
        vecs.push_back(mk(NP,PO,NP,NP, 0,0,0,0, 4'b0100,0,0,1,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,1,2, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,PO,NP,NP, 0,0,0,0, 4'b0100,0,0,2,0));
        // engine 1 back-to-back pushes wait for retire
        vecs.push_back(mk(NP,NP,PU,NP, 0,0,0,0, 4'b0010,1,0,1,0));
        vecs.push_back(mk(NP,NP,PU,NP, 0,0,0,0, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,NP,PU,NP, 0,0,1,1, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,NP,PU,NP, 0,0,0,0, 4'b0010,1,0,1,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,1,1, 4'b0000,0,1,0,0));
        // engine 1 now full: overflow even with free list empty
        vecs.push_back(mk(NP,NP,PU,NP, 1,0,0,0, 4'b0010,0,0,2,1));
        vecs.push_back(mk(NP,NP,PU,NP, 0,0,0,0, 4'b0010,0,0,2,1));
        // empty free list blocks push only
        vecs.push_back(mk(PO,NP,NP,PU, 1,0,0,0, 4'b1000,0,0,1,0));
        vecs.push_back(mk(NP,NP,NP,PU, 0,0,0,0, 4'b0001,1,1,1,0));
        vecs.push_back(mk(NP,PU,NP,NP, 0,1,1,3, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,PU,NP,NP, 0,0,1,0, 4'b0100,1,1,1,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,1,2, 4'b0000,0,1,0,0));
        vecs.push_back(mk(NP,NP,NP,NP, 0,0,0,0, 4'b0000,0,0,0,0));
        // pointer wrap and mixed issue/error
        vecs.push_back(mk(PU,PU,PU,PU, 0,0,0,0, 4'b1000,1,0,1,0));
        vecs.push_back(mk(NP,PU,PU,PU, 0,0,0,0, 4'b0001,1,1,1,0));
        vecs.push_back(mk(NP,PU,PU,NP, 0,0,0,0, 4'b0010,0,1,2,1));
        vecs.push_back(mk(NP,PU,NP,NP, 0,0,0,0, 4'b0100,1,1,1,0));
        vecs.push_back(mk(RS,RS,RS,RS, 0,0,0,0, 4'b0000,0,1,0,0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // reset one cycle after a grant squashes the LK pulse
        opc = {NP, NP, PO, NP};
        rv = 1'b0;
        #1;
        chk("pre_rst_ack", 128'(ack), 128'(4'b0010));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("sq_lk_vld", 128'(lk_vld), 128'(0));
        chk("sq_busy", 128'(busy), 128'(0));
        chk("sq_ack", 128'(ack), 128'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("sq_lk_vld2", 128'(lk_vld), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        opc = {PU, NP, PU, NP};
        #1;
        chk("post_ack", 128'(ack), 128'(4'b0010));
        chk("post_alloc", 128'(alloc), 128'(1));
        chk("post_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        chk("post_lk_vld", 128'(lk_vld), 128'(1));
        chk("post_lk_engid", 128'(lk_engid), 128'(1));
        chk("post_lk_opcode", 128'(lk_opcode), 128'(PU));
        chk("post_lk_dat", lk_dat, pat(1));
        @(negedge clk);
        opc = {NP, NP, NP, PO};
        #1;
        chk("post_pop_ack", 128'(ack), 128'(4'b0001));
        chk("post_pop_alloc", 128'(alloc), 128'(0));
        @(posedge clk);
        #1;
        chk("post_err_vld", 128'(err_vld), 128'(1));
        chk("post_err_engid", 128'(err_engid), 128'(0));
        chk("post_err_ovf", 128'(err_ovf), 128'(0));
        chk("post_lk_vld0", 128'(lk_vld), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
